// File: rtl/rx_pkg.sv
// Shared constants for the receive sample scheduler.
//   - FSM state encoding (binary, 3 bits)
//   - default sequence count and band-pass decimation ratio
//   - decimated sample counter width and the ADC sample period in clock cycles
package rx_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t StIdle = 3'd0;
  localparam rx_state_t StLp   = 3'd1;
  localparam rx_state_t StBp   = 3'd2;
  localparam rx_state_t StCorr = 3'd3;
  localparam rx_state_t StDone = 3'd4;

  localparam int unsigned N_SEQ_DEFAULT = 16;
  localparam int unsigned DECIM_DEFAULT = 4;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned SEQ_IDX_W     = 4;
  // Clock cycles between ADC sample triggers; one full pass must fit inside.
  localparam int unsigned SAMPLE_PERIOD = 128;

endpackage

// File: rtl/rx_seq_counter.sv
// Load/enable up-counter with terminal-count flag.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset, clears the count
//   load_i     : load load_val_i (has priority over en_i)
//   en_i       : increment by one
//   load_val_i : value taken on load
//   count_o    : registered count
//   tc_o       : high while count_o equals Last
module rx_seq_counter #(
  parameter int unsigned Width = 4,
  parameter int unsigned Last  = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == Width'(Last));

endmodule

// File: rtl/rx_sample_scheduler.sv
// Sequences the per-sample receive pipeline: one low-pass step, one band-pass
// step, and on every DECIM-th sample N_SEQ correlator steps followed by a
// result-valid strobe.
//   crx_clk         : clock, rising edge
//   rrx_rst         : synchronous active-high reset
//   erx_en          : enable; low aborts any pass in flight and ignores triggers
//   inew_sample_trig: one-cycle strobe for a new ADC sample
//   olp_en          : low-pass step strobe
//   obp_en          : band-pass step strobe
//   ocorr_en        : correlator step enable (N_SEQ cycles)
//   ocorr_seq_idx   : sequence index during correlation, 0 otherwise
//   oresult_valid   : one-cycle strobe, all correlator results stable
//   osample_cnt     : count of decimated samples, wraps silently
//   obusy           : FSM not idle
//   ooverrun        : sticky, a trigger arrived while busy
module rx_sample_scheduler
  import rx_pkg::*;
#(
  parameter int unsigned N_SEQ = N_SEQ_DEFAULT,
  parameter int unsigned DECIM = DECIM_DEFAULT
) (
  input  logic                 crx_clk,
  input  logic                 rrx_rst,
  input  logic                 erx_en,
  input  logic                 inew_sample_trig,
  output logic                 olp_en,
  output logic                 obp_en,
  output logic                 ocorr_en,
  output logic [SEQ_IDX_W-1:0] ocorr_seq_idx,
  output logic                 oresult_valid,
  output logic [CNT_W-1:0]     osample_cnt,
  output logic                 obusy,
  output logic                 ooverrun
);

  localparam int unsigned DecimW = (DECIM > 1) ? $clog2(DECIM) : 1;

  rx_state_t         state_q, state_d;
  logic [DecimW-1:0] decim_q, decim_d;
  logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
  logic              overrun_q, overrun_d;
  logic              lp_q, bp_q, corr_q, result_valid_q, busy_q;

  logic                 seq_load, seq_en, seq_tc;
  logic [SEQ_IDX_W-1:0] seq_idx;

  always_comb begin
    state_d      = state_q;
    decim_d      = decim_q;
    sample_cnt_d = sample_cnt_q;
    overrun_d    = overrun_q;

    // Only a registered-idle FSM accepts a trigger, so one landing on the
    // DONE->IDLE edge is still dropped.
    if (erx_en && inew_sample_trig && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    if (!erx_en) begin
      // Abort: counters keep their values, no result strobe.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: if (inew_sample_trig) state_d = StLp;
        StLp:   state_d = StBp;
        StBp: begin
          decim_d = (decim_q == DecimW'(DECIM - 1)) ? '0 : decim_q + DecimW'(1);
          state_d = (decim_q == '0) ? StCorr : StIdle;
        end
        StCorr: if (seq_tc) state_d = StDone;
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    if (state_d == StDone) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
    end
  end

  // Index sits at 0 outside CORR, holds 0 on the entry edge, then steps.
  assign seq_load = (state_d != StCorr);
  assign seq_en   = (state_q == StCorr) && (state_d == StCorr);

  rx_seq_counter #(
    .Width(SEQ_IDX_W),
    .Last (N_SEQ - 1)
  ) u_seq_counter (
    .clk_i     (crx_clk),
    .rst_i     (rrx_rst),
    .load_i    (seq_load),
    .en_i      (seq_en),
    .load_val_i('0),
    .count_o   (seq_idx),
    .tc_o      (seq_tc)
  );

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge crx_clk) begin
    if (rrx_rst) begin
      state_q        <= StIdle;
      decim_q        <= '0;
      sample_cnt_q   <= '0;
      overrun_q      <= 1'b0;
      lp_q           <= 1'b0;
      bp_q           <= 1'b0;
      corr_q         <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      decim_q        <= decim_d;
      sample_cnt_q   <= sample_cnt_d;
      overrun_q      <= overrun_d;
      lp_q           <= (state_d == StLp);
      bp_q           <= (state_d == StBp);
      corr_q         <= (state_d == StCorr);
      result_valid_q <= (state_d == StDone);
      busy_q         <= (state_d != StIdle);
    end
  end

  assign olp_en        = lp_q;
  assign obp_en        = bp_q;
  assign ocorr_en      = corr_q;
  assign ocorr_seq_idx = seq_idx;
  assign oresult_valid = result_valid_q;
  assign osample_cnt   = sample_cnt_q;
  assign obusy         = busy_q;
  assign ooverrun      = overrun_q;

endmodule

// File: tb/tb_rx_sample_scheduler.sv
// Directed bench for rx_sample_scheduler with default parameters.
module tb_rx_sample_scheduler;

  logic        crx_clk;
  logic        rrx_rst;
  logic        erx_en;
  logic        inew_sample_trig;
  logic        olp_en;
  logic        obp_en;
  logic        ocorr_en;
  logic [3:0]  ocorr_seq_idx;
  logic        oresult_valid;
  logic [15:0] osample_cnt;
  logic        obusy;
  logic        ooverrun;

  int n_checks = 0;
  int n_fail   = 0;

  rx_sample_scheduler dut (
    .crx_clk         (crx_clk),
    .rrx_rst         (rrx_rst),
    .erx_en          (erx_en),
    .inew_sample_trig(inew_sample_trig),
    .olp_en          (olp_en),
    .obp_en          (obp_en),
    .ocorr_en        (ocorr_en),
    .ocorr_seq_idx   (ocorr_seq_idx),
    .oresult_valid   (oresult_valid),
    .osample_cnt     (osample_cnt),
    .obusy           (obusy),
    .ooverrun        (ooverrun)
  );

  initial begin
    crx_clk = 1'b0;
    forever #5 crx_clk = ~crx_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge crx_clk);
    #1;
  endtask

  // {lp, bp, corr, idx[3:0], result_valid, busy, overrun}
  function automatic logic [31:0] obs();
    return {22'd0, olp_en, obp_en, ocorr_en, ocorr_seq_idx, oresult_valid, obusy, ooverrun};
  endfunction

  task automatic reset_dut();
    rrx_rst = 1'b1;
    erx_en = 1'b1;
    inew_sample_trig = 1'b0;
    tick();
    tick();
    rrx_rst = 1'b0;
    tick();
  endtask

  // Trigger at edge T, optional second trigger at T+t2, erx_en low from T+d,
  // reset pulse at T+r (0 = unused). Observation k is cycle T+k.
  task automatic run_op(input string tag, input int t2, input int d, input int r,
                        input logic [15:0] base);
    int abort;
    logic done_ok, alive, lp, bp, corr, rv, busy, ovr;
    logic [3:0]  idx;
    logic [15:0] cnt;
    logic [31:0] exp_v;
    abort = (d != 0 && (r == 0 || d < r)) ? d : r;
    done_ok = (abort == 0) || (abort > 18);
    for (int k = 1; k <= 24; k++) begin
      inew_sample_trig = (k == 1) || (t2 != 0 && k - 1 == t2);
      erx_en = !(d != 0 && k - 1 >= d);
      rrx_rst = (r != 0 && k - 1 == r);
      tick();
      alive = (abort == 0) || (k <= abort);
      lp    = alive && (k == 1);
      bp    = alive && (k == 2);
      corr  = alive && (k >= 3) && (k <= 18);
      idx   = corr ? 4'(k - 3) : 4'd0;
      rv    = alive && (k == 19);
      busy  = alive && (k <= 19);
      ovr   = (t2 >= 1) && (t2 <= 19) && (abort == 0 || t2 < abort) && (k > t2)
              && (r == 0 || k <= r);
      cnt   = (done_ok && k >= 19) ? base + 16'd1 : base;
      if (r != 0 && k > r) cnt = 16'd0;
      exp_v = {22'd0, lp, bp, corr, idx, rv, busy, ovr};
      check_eq($sformatf("%s_out_k%0d", tag, k), obs(), exp_v);
      check_eq($sformatf("%s_cnt_k%0d", tag, k), 32'(osample_cnt), 32'(cnt));
    end
    inew_sample_trig = 1'b0;
    erx_en = 1'b1;
    rrx_rst = 1'b0;
  endtask

  initial begin
    int lp_n, bp_n, rv_n;
    logic corr_seen;
    rrx_rst = 1'b0;
    erx_en = 1'b0;
    inew_sample_trig = 1'b0;

    // Reset wins over enable and trigger.
    rrx_rst = 1'b1;
    erx_en = 1'b1;
    inew_sample_trig = 1'b1;
    tick();
    tick();
    check_eq("reset_out", obs(), 32'd0);
    check_eq("reset_cnt", 32'(osample_cnt), 32'd0);
    rrx_rst = 1'b0;
    inew_sample_trig = 1'b0;
    tick();
    check_eq("post_reset_out", obs(), 32'd0);

    // Trigger with enable low is ignored and does not flag overrun.
    erx_en = 1'b0;
    inew_sample_trig = 1'b1;
    tick();
    inew_sample_trig = 1'b0;
    erx_en = 1'b1;
    tick();
    check_eq("en_low_trig", obs(), 32'd0);

    reset_dut();
    run_op("basic", 0, 0, 0, 16'd0);
    reset_dut();
    run_op("ovr", 10, 0, 0, 16'd0);
    reset_dut();
    run_op("done_trig", 19, 0, 0, 16'd0);
    reset_dut();
    run_op("abort", 10, 8, 0, 16'd0);

    reset_dut();
    force dut.sample_cnt_q = 16'hFFFF;
    tick();
    release dut.sample_cnt_q;
    tick();
    check_eq("preset_cnt", 32'(osample_cnt), 32'h0000_FFFF);
    run_op("wrap", 0, 0, 0, 16'hFFFF);

    reset_dut();
    run_op("rst", 5, 0, 12, 16'd0);

    // Eight triggers one sample period apart: correlate on 1st and 5th only.
    reset_dut();
    lp_n = 0;
    bp_n = 0;
    rv_n = 0;
    for (int i = 0; i < 8; i++) begin
      corr_seen = 1'b0;
      for (int j = 0; j < 128; j++) begin
        inew_sample_trig = (j == 0);
        tick();
        lp_n += int'(olp_en);
        bp_n += int'(obp_en);
        rv_n += int'(oresult_valid);
        if (ocorr_en) corr_seen = 1'b1;
      end
      inew_sample_trig = 1'b0;
      check_eq($sformatf("decim_corr_t%0d", i), 32'(corr_seen), 32'((i == 0) || (i == 4)));
    end
    check_eq("decim_lp_pulses", 32'(lp_n), 32'd8);
    check_eq("decim_bp_pulses", 32'(bp_n), 32'd8);
    check_eq("decim_rv_pulses", 32'(rv_n), 32'd2);
    check_eq("decim_cnt", 32'(osample_cnt), 32'd2);
    check_eq("decim_overrun", 32'(ooverrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_sample_scheduler.md
RX_SAMPLE_SCHEDULER -- requirements
Module: rx_sample_scheduler

Interface
REQ-001 The block SHALL have parameter N_SEQ, default 16, the number of correlator sequences evaluated per decimated sample.
REQ-002 The block SHALL have parameter DECIM, default 4, the band-pass decimation ratio (power of two).
REQ-003 The block SHALL have port crx_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rrx_rst, input, 1, the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port erx_en, input, 1, the enable; when low, the block does not accept new samples.
REQ-006 The block SHALL have port inew_sample_trig, input, 1, a one-cycle strobe that marks a new ADC sample on inew_sample.
REQ-007 The block SHALL have port olp_en, output, 1, the low-pass filter step strobe.
REQ-008 The block SHALL have port obp_en, output, 1, the band-pass filter step strobe.
REQ-009 The block SHALL have port ocorr_en, output, 1, the correlator step enable.
REQ-010 The block SHALL have port ocorr_seq_idx, output, 4, the index of the sequence being correlated.
REQ-011 The block SHALL have port oresult_valid, output, 1, a one-cycle strobe meaning all N_SEQ results are stable.
REQ-012 The block SHALL have port osample_cnt, output, 16, the count of decimated samples.
REQ-013 The block SHALL have port obusy, output, 1, high whenever the FSM is not in IDLE.
REQ-014 The block SHALL have port ooverrun, output, 1, a sticky flag for a dropped trigger.

Function
REQ-015 The FSM SHALL have states IDLE, LP, BP, CORR and DONE; it is one-hot-free encoded with 3 bits.
REQ-016 In IDLE with erx_en=1 and inew_sample_trig=1 at edge T, the FSM SHALL enter LP; olp_en SHALL be 1 during cycle T+1 only.
REQ-017 LP SHALL go to BP unconditionally; obp_en SHALL be 1 during cycle T+2 only.
REQ-018 In BP, the 2-bit decimation counter SHALL increment modulo DECIM.
REQ-019 In BP, if the decimation counter was 0 before the increment, the FSM SHALL go to CORR; otherwise it SHALL return to IDLE.
REQ-020 In CORR, ocorr_en SHALL be 1 for exactly N_SEQ consecutive cycles, T+3 .. T+2+N_SEQ.
REQ-021 In CORR, ocorr_seq_idx SHALL step 0,1,..,N_SEQ-1 in those cycles.
REQ-022 After the CORR cycle with index N_SEQ-1, the FSM SHALL enter DONE.
REQ-023 In DONE, at cycle T+3+N_SEQ, oresult_valid SHALL be 1 for one cycle and osample_cnt SHALL increment; the FSM SHALL then return to IDLE.
REQ-024 Worst-case occupancy SHALL be N_SEQ+3 cycles, which is 19 with defaults and well inside the 128-cycle sample period.
REQ-025 osample_cnt SHALL wrap from 0xFFFF to 0x0000 without setting any flag.
REQ-026 A trigger arriving when the FSM is not in IDLE SHALL be dropped, SHALL set ooverrun, and SHALL NOT disturb the operation in flight.
REQ-027 ooverrun SHALL be cleared only by reset.
REQ-028 A trigger in the same cycle as the DONE->IDLE transition SHALL count as an overrun; a trigger is accepted only while the FSM is registered IDLE.
REQ-029 If erx_en falls mid-operation, the FSM SHALL abort to IDLE on the next edge and all strobes SHALL be 0 from then on.
REQ-030 An abort SHALL leave the decimation counter and osample_cnt unchanged, and SHALL NOT issue oresult_valid.
REQ-031 Any trigger while erx_en=0 SHALL be ignored and SHALL NOT set ooverrun.
REQ-032 ocorr_seq_idx SHALL be 0 whenever ocorr_en=0.
REQ-033 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Reset
REQ-034 Reset SHALL set the FSM to IDLE.
REQ-035 Reset SHALL clear the decimation counter, osample_cnt, ocorr_seq_idx and ooverrun.
REQ-036 Reset SHALL drive every strobe output and obusy to 0.
REQ-037 Reset SHALL take priority over erx_en and inew_sample_trig.
REQ-038 Reset asserted mid-CORR SHALL abandon the operation without issuing oresult_valid.

Structure
REQ-039 A package rx_pkg SHALL hold the state encoding, N_SEQ/DECIM defaults, the 16-bit counter width and the 128-cycle SAMPLE_PERIOD constant.
REQ-040 The design SHALL use one sub-module, rx_seq_counter: a load/enable counter with terminal-count output, used for ocorr_seq_idx.

Verification
REQ-041 Scenario: reset, then one trigger -> olp_en at T+1, obp_en at T+2, ocorr_en T+3..T+18 with idx 0..15, oresult_valid at T+19, osample_cnt=1.
REQ-042 Scenario: 8 triggers spaced 128 cycles -> CORR entered on triggers 1 and 5 only; osample_cnt=2; 8 olp_en and 8 obp_en pulses.
REQ-043 Scenario: second trigger at T+10 -> ooverrun=1, first operation completes unchanged, osample_cnt=1.
REQ-044 Scenario: erx_en dropped at T+8 -> strobes 0 from T+9, no oresult_valid, osample_cnt=0; ooverrun stays 0.
REQ-045 Scenario: osample_cnt preset to 0xFFFF via forced DONE -> next oresult_valid gives 0x0000.
REQ-046 Scenario: rrx_rst asserted at T+12 -> next cycle all outputs 0, FSM IDLE, ooverrun=0.
